// File: rtl/node_inject_queue_pkg.sv
// Shared types for the node injection path: crossbar packet and the un-stamped node request.
package node_inject_queue_pkg;

    localparam int unsigned ADDR_W = 48;
    // Node-ID field width of the network packet; sized for up to 8 nodes so an
    // out-of-range destination can still be carried and observed downstream.
    localparam int unsigned ID_W   = 3;

    typedef struct packed {
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   dest;
        logic [ADDR_W-1:0] memoryAddress;
    } pkt_t;

    typedef struct packed {
        logic [ID_W-1:0]   dest;
        logic [ADDR_W-1:0] memoryAddress;
    } inject_req_t;

    function automatic pkt_t stamp_pkt(input logic [ID_W-1:0] src, input inject_req_t req);
        pkt_t p;
        p.src           = src;
        p.dest          = req.dest;
        p.memoryAddress = req.memoryAddress;
        return p;
    endfunction

endpackage

// File: rtl/node_inject_queue_fifo.sv
// Circular-buffer FIFO; full/empty are derived from the entry count, not the pointers.
module node_inject_queue_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_l,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH):0]     o_count_next
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    // Requests against a full or empty queue are simply not performed.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign o_count_next = w_count_next;

endmodule

// File: rtl/node_inject_queue.sv
// Per-node injection buffer in front of the crossbar: queues node requests, stamps the source
// ID, holds the head until the crossbar takes it, and tracks occupancy and error conditions.
module node_inject_queue
    import node_inject_queue_pkg::*;
#(
    parameter int unsigned NUM_PROC = 4,
    parameter int unsigned NODE_ID  = 0,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_l,
    input  logic              i_enq_valid,
    input  logic [ID_W-1:0]   i_enq_dest,
    input  logic [ADDR_W-1:0] i_enq_addr,
    output logic              o_enq_ready,
    output pkt_t              o_pkt_out,
    output logic              o_pkt_valid,
    input  logic              i_pkt_taken,
    output logic [CNT_W-1:0]  o_occupancy,
    output logic [CNT_W-1:0]  o_high_water,
    output logic              o_err_underflow,
    output logic              o_err_bad_dest
);

    inject_req_t      w_enq_req;
    inject_req_t      w_head_req;
    logic             w_full;
    logic             w_empty;
    logic             w_enq_fire;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] r_high_water;
    logic             r_err_underflow;
    logic             r_err_bad_dest;

    assign w_enq_req.dest          = i_enq_dest;
    assign w_enq_req.memoryAddress = i_enq_addr;
    assign w_enq_fire              = i_enq_valid && !w_full;

    node_inject_queue_fifo #(
        .T     (inject_req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_l      (i_rst_l),
        .i_push       (i_enq_valid),
        .i_data       (w_enq_req),
        .i_pop        (i_pkt_taken),
        .o_head       (w_head_req),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_high_water    <= '0;
            r_err_underflow <= 1'b0;
            r_err_bad_dest  <= 1'b0;
        end else begin
            if (w_count_next > r_high_water) begin
                r_high_water <= w_count_next;
            end
            if (i_pkt_taken && w_empty) begin
                r_err_underflow <= 1'b1;
            end
            if (w_enq_fire && (32'(i_enq_dest) >= NUM_PROC)) begin
                r_err_bad_dest <= 1'b1;
            end
        end
    end

    // Gating on occupancy keeps unwritten storage off the crossbar and zeroes the bus in reset.
    assign o_pkt_valid     = !w_empty;
    assign o_pkt_out       = o_pkt_valid ? stamp_pkt(ID_W'(NODE_ID), w_head_req) : '0;
    assign o_enq_ready     = !w_full;
    assign o_occupancy     = w_count;
    assign o_high_water    = r_high_water;
    assign o_err_underflow = r_err_underflow;
    assign o_err_bad_dest  = r_err_bad_dest;

endmodule

// File: tb/tb_node_inject_queue.sv
// Directed bench for node_inject_queue with NODE_ID=1, NUM_PROC=4, DEPTH=8.
module tb_node_inject_queue;
    import node_inject_queue_pkg::*;

    logic              clk;
    logic              rst_l;
    logic              enq_valid;
    logic [ID_W-1:0]   enq_dest;
    logic [ADDR_W-1:0] enq_addr;
    logic              enq_ready;
    pkt_t              pkt_out;
    logic              pkt_valid;
    logic              pkt_taken;
    logic [3:0]        occupancy;
    logic [3:0]        high_water;
    logic              err_underflow;
    logic              err_bad_dest;

    int total;
    int bad;

    node_inject_queue #(
        .NUM_PROC (4),
        .NODE_ID  (1),
        .DEPTH    (8)
    ) dut (
        .i_clk           (clk),
        .i_rst_l         (rst_l),
        .i_enq_valid     (enq_valid),
        .i_enq_dest      (enq_dest),
        .i_enq_addr      (enq_addr),
        .o_enq_ready     (enq_ready),
        .o_pkt_out       (pkt_out),
        .o_pkt_valid     (pkt_valid),
        .i_pkt_taken     (pkt_taken),
        .o_occupancy     (occupancy),
        .o_high_water    (high_water),
        .o_err_underflow (err_underflow),
        .o_err_bad_dest  (err_bad_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_l     = 1'b0;
        enq_valid = 1'b0;
        enq_dest  = '0;
        enq_addr  = '0;
        pkt_taken = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        step();
    endtask

    task automatic push(input logic [ID_W-1:0] d, input logic [ADDR_W-1:0] a);
        enq_valid = 1'b1;
        enq_dest  = d;
        enq_addr  = a;
        step();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_l     = 1'b0;
        enq_valid = 1'b0;
        enq_dest  = '0;
        enq_addr  = '0;
        pkt_taken = 1'b0;
        #12;
        total++;
        if (pkt_valid !== 1'b0 || occupancy !== 4'd0 || high_water !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: valid=%b occ=%0d hw=%0d, want 0 0 0",
                     pkt_valid, occupancy, high_water);
        end
        total++;
        if (pkt_out !== '0 || err_underflow !== 1'b0 || err_bad_dest !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: pkt=%h uf=%b bd=%b, want 0 0 0",
                     pkt_out, err_underflow, err_bad_dest);
        end
        @(negedge clk);
        rst_l = 1'b1;
        step();
        total++;
        if (enq_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", enq_ready);
        end
    endtask

    task automatic test_single();
        pkt_t exp;
        exp.src           = 3'd1;
        exp.dest          = 3'd2;
        exp.memoryAddress = 48'h1234;
        total++;
        if (pkt_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pre_valid: got %b want 0", pkt_valid);
        end
        push(3'd2, 48'h1234);
        total++;
        if (pkt_valid !== 1'b1 || pkt_out !== exp || occupancy !== 4'd1) begin
            bad++;
            $display("FAIL single_present: valid=%b pkt=%h occ=%0d, want 1 %h 1",
                     pkt_valid, pkt_out, occupancy, exp);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (pkt_valid !== 1'b1 || pkt_out !== exp) begin
                bad++;
                $display("FAIL single_hold[%0d]: valid=%b pkt=%h, want 1 %h",
                         i, pkt_valid, pkt_out, exp);
            end
        end
        pkt_taken = 1'b1;
        step();
        pkt_taken = 1'b0;
        total++;
        if (pkt_valid !== 1'b0 || occupancy !== 4'd0) begin
            bad++;
            $display("FAIL single_taken: valid=%b occ=%0d, want 0 0", pkt_valid, occupancy);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (enq_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill_ready[%0d]: got %b want 1", i, enq_ready);
            end
            push(3'(i % 4), 48'(i));
        end
        total++;
        if (enq_ready !== 1'b0 || occupancy !== 4'd8) begin
            bad++;
            $display("FAIL fill_full: ready=%b occ=%0d, want 0 8", enq_ready, occupancy);
        end
        push(3'd0, 48'd99);
        total++;
        if (occupancy !== 4'd8 || high_water !== 4'd8) begin
            bad++;
            $display("FAIL fill_drop9: occ=%0d hw=%0d, want 8 8", occupancy, high_water);
        end
        pkt_taken = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (pkt_valid !== 1'b1 || pkt_out.memoryAddress !== 48'(i)) begin
                bad++;
                $display("FAIL fill_drain[%0d]: valid=%b addr=%0d, want 1 %0d",
                         i, pkt_valid, pkt_out.memoryAddress, i);
            end
            step();
        end
        pkt_taken = 1'b0;
        total++;
        if (pkt_valid !== 1'b0 || occupancy !== 4'd0 || err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL fill_empty: valid=%b occ=%0d uf=%b, want 0 0 0",
                     pkt_valid, occupancy, err_underflow);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) push(3'd3, 48'(100 + i));
        for (int i = 0; i < 20; i++) begin
            enq_valid = 1'b1;
            enq_dest  = 3'd3;
            enq_addr  = 48'(103 + i);
            pkt_taken = 1'b1;
            total++;
            if (pkt_out.memoryAddress !== 48'(100 + i) || occupancy !== 4'd3) begin
                bad++;
                $display("FAIL wrap[%0d]: addr=%0d occ=%0d, want %0d 3",
                         i, pkt_out.memoryAddress, occupancy, 100 + i);
            end
            step();
        end
        enq_valid = 1'b0;
        pkt_taken = 1'b0;
        total++;
        if (occupancy !== 4'd3 || high_water !== 4'd3) begin
            bad++;
            $display("FAIL wrap_hw: occ=%0d hw=%0d, want 3 3", occupancy, high_water);
        end
        pkt_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (pkt_out.memoryAddress !== 48'(120 + i)) begin
                bad++;
                $display("FAIL wrap_tail[%0d]: addr=%0d want %0d",
                         i, pkt_out.memoryAddress, 120 + i);
            end
            step();
        end
        pkt_taken = 1'b0;
    endtask

    task automatic test_full_take();
        do_reset();
        for (int i = 0; i < 8; i++) push(3'd2, 48'(200 + i));
        enq_valid = 1'b1;
        enq_dest  = 3'd2;
        enq_addr  = 48'd300;
        pkt_taken = 1'b1;
        total++;
        if (enq_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_take_ready: got %b want 0", enq_ready);
        end
        step();
        pkt_taken = 1'b0;
        total++;
        if (occupancy !== 4'd7 || enq_ready !== 1'b1 || pkt_out.memoryAddress !== 48'd201) begin
            bad++;
            $display("FAIL full_take_pop: occ=%0d ready=%b addr=%0d, want 7 1 201",
                     occupancy, enq_ready, pkt_out.memoryAddress);
        end
        step();
        enq_valid = 1'b0;
        total++;
        if (occupancy !== 4'd8) begin
            bad++;
            $display("FAIL full_take_accept: occ=%0d want 8", occupancy);
        end
        pkt_taken = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (pkt_out.memoryAddress !== ((i == 7) ? 48'd300 : 48'(201 + i))) begin
                bad++;
                $display("FAIL full_take_order[%0d]: addr=%0d want %0d",
                         i, pkt_out.memoryAddress, (i == 7) ? 300 : 201 + i);
            end
            step();
        end
        pkt_taken = 1'b0;
    endtask

    task automatic test_errors();
        pkt_t exp;
        do_reset();
        pkt_taken = 1'b1;
        step();
        pkt_taken = 1'b0;
        total++;
        if (err_underflow !== 1'b1 || occupancy !== 4'd0 || pkt_valid !== 1'b0) begin
            bad++;
            $display("FAIL underflow_set: uf=%b occ=%0d valid=%b, want 1 0 0",
                     err_underflow, occupancy, pkt_valid);
        end
        step();
        total++;
        if (err_underflow !== 1'b1) begin
            bad++;
            $display("FAIL underflow_sticky: got %b want 1", err_underflow);
        end
        total++;
        if (err_bad_dest !== 1'b0) begin
            bad++;
            $display("FAIL bad_dest_pre: got %b want 0", err_bad_dest);
        end
        push(3'd5, 48'hABC);
        exp.src           = 3'd1;
        exp.dest          = 3'd5;
        exp.memoryAddress = 48'hABC;
        total++;
        if (err_bad_dest !== 1'b1 || pkt_valid !== 1'b1 || pkt_out !== exp) begin
            bad++;
            $display("FAIL bad_dest: bd=%b valid=%b pkt=%h, want 1 1 %h",
                     err_bad_dest, pkt_valid, pkt_out, exp);
        end
        // Empty queue: enqueue completes while the concurrent take counts as underflow.
        do_reset();
        enq_valid = 1'b1;
        enq_dest  = 3'd1;
        enq_addr  = 48'h77;
        pkt_taken = 1'b1;
        step();
        enq_valid = 1'b0;
        pkt_taken = 1'b0;
        exp.dest          = 3'd1;
        exp.memoryAddress = 48'h77;
        total++;
        if (err_underflow !== 1'b1 || occupancy !== 4'd1 || pkt_out !== exp
            || err_bad_dest !== 1'b0) begin
            bad++;
            $display("FAIL empty_enq_take: uf=%b occ=%0d pkt=%h bd=%b, want 1 1 %h 0",
                     err_underflow, occupancy, pkt_out, err_bad_dest, exp);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) push(3'd0, 48'(400 + i));
        pkt_taken = 1'b1;
        step();
        step();
        pkt_taken = 1'b0;
        total++;
        if (occupancy !== 4'd4 || pkt_out.memoryAddress !== 48'd402) begin
            bad++;
            $display("FAIL async_pre: occ=%0d addr=%0d, want 4 402",
                     occupancy, pkt_out.memoryAddress);
        end
        #3;
        rst_l = 1'b0;
        #1;
        total++;
        if (pkt_valid !== 1'b0 || occupancy !== 4'd0 || high_water !== 4'd0
            || pkt_out !== '0) begin
            bad++;
            $display("FAIL async_reset: valid=%b occ=%0d hw=%0d pkt=%h, want 0 0 0 0",
                     pkt_valid, occupancy, high_water, pkt_out);
        end
        @(negedge clk);
        rst_l = 1'b1;
        step();
        enq_valid = 1'b1;
        enq_dest  = 3'd3;
        enq_addr  = 48'd500;
        total++;
        if (pkt_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_no_bypass: got %b want 0", pkt_valid);
        end
        step();
        enq_valid = 1'b0;
        total++;
        if (pkt_valid !== 1'b1 || pkt_out.memoryAddress !== 48'd500 || occupancy !== 4'd1) begin
            bad++;
            $display("FAIL async_first: valid=%b addr=%0d occ=%0d, want 1 500 1",
                     pkt_valid, pkt_out.memoryAddress, occupancy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_full_take();
        test_errors();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
